// File: rtl/modpow_pkg.sv
// Shared parameters and state encoding for the ModPow_4096 I/O shell.
package modpow_pkg;
  localparam int K          = 128;
  localparam int WORDS      = 32;
  localparam int AW         = 5;
  localparam int LOAD_BEATS = 3 * WORDS + 1;
  localparam int BW         = 7;   // beat counter width, holds 0..LOAD_BEATS-1

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, REQ, CAPT, DRAIN} state_t;
endpackage

// File: rtl/modpow_io_ctrl_if.sv
// Job input stream, core write/result port and result output stream of the ModPow I/O shell.
interface modpow_io_if;
  import modpow_pkg::*;

  logic          s_valid;
  logic          s_ready;
  logic [K-1:0]  s_data;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_X;
  logic [K-1:0]  wr_N;
  logic [K-1:0]  wr_E;
  logic [K-1:0]  wr_W;
  logic          task_req;
  logic          task_grant;
  logic [K-1:0]  task_res;
  logic          task_end;
  logic          m_valid;
  logic          m_ready;
  logic [K-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          err;

  // slave: the shell itself; master: the job source, core and result sink around it
  modport slave (
    input  s_valid, s_data, task_grant, task_res, task_end, m_ready,
    output s_ready, wr_ena, wr_addr, wr_X, wr_N, wr_E, wr_W, task_req,
           m_valid, m_data, m_last, busy, err
  );
  modport master (
    output s_valid, s_data, task_grant, task_res, task_end, m_ready,
    input  s_ready, wr_ena, wr_addr, wr_X, wr_N, wr_E, wr_W, task_req,
           m_valid, m_data, m_last, busy, err
  );
endinterface

// File: rtl/simple_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module simple_ram #(
  parameter int WIDTH   = 128,
  parameter int WIDTHAD = 6,
  parameter int DEEP    = 33
) (
  input  logic               clk,
  input  logic               wren,
  input  logic [WIDTHAD-1:0] wraddr,
  input  logic [WIDTH-1:0]   data,
  input  logic [WIDTHAD-1:0] rdaddr,
  output logic [WIDTH-1:0]   q
);
  logic [WIDTH-1:0] mem [DEEP];

  always_ff @(posedge clk) begin
    if (wren) mem[wraddr] <= data;
    q <= mem[rdaddr];
  end
endmodule

// File: rtl/modpow_io_ctrl.sv
// Buffers one modexp job, replays it into the core, captures the result and streams it out.
module modpow_io_ctrl
  import modpow_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  modpow_io_if.slave  io
);
  localparam logic [AW:0]   WORDS_C   = (AW+1)'(WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LOAD_BEATS - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [K-1:0]  w_q, w_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   cap_q, cap_d, rd_q, rd_d, cap_now;
  logic          wr_ena_q, wr_ena_d, err_q, err_d, s_ready_q, s_ready_d;
  logic          task_req_q, task_req_d, m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d, busy_q, busy_d;
  logic          accept, handshake, grant, cap_ok;
  logic [K-1:0]  op_q [3];
  logic [K-1:0]  res_q;

  assign accept    = io.s_valid & s_ready_q;
  assign handshake = m_valid_q & io.m_ready;
  assign grant     = io.task_grant & ((state_q == REQ) | (state_q == CAPT));
  assign cap_ok    = grant & (cap_q != WORDS_C);
  assign cap_now   = cap_q + (AW+1)'(cap_ok);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    w_d       = w_q;
    wr_addr_d = '0;
    cap_d     = cap_q;
    rd_d      = rd_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE, LOAD: if (accept) begin
        if (beat_q == LAST_BEAT) begin
          state_d = WRITE;
          beat_d  = '0;
          w_d     = io.s_data;
        end else begin
          state_d = LOAD;
          beat_d  = beat_q + 1'b1;
        end
      end
      WRITE: begin
        if (wr_addr_q == AW'(WORDS - 1)) begin
          state_d = REQ;
          cap_d   = '0;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      REQ, CAPT: if ((state_q == CAPT) || io.task_grant) begin
        state_d = CAPT;
        cap_d   = cap_now;
        if (grant && !cap_ok) err_d = 1'b1;
        if (io.task_end) begin
          if (cap_now == WORDS_C) begin
            state_d = DRAIN;
            rd_d    = '0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: if (handshake) begin
        rd_d = rd_q + 1'b1;
        if (rd_q == WORDS_C - 1'b1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    s_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    wr_ena_d   = (state_d == WRITE);
    task_req_d = (state_d == REQ);
    m_valid_d  = (state_d == DRAIN);
    m_last_d   = (state_d == DRAIN) && (rd_d == WORDS_C - 1'b1);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      w_q        <= '0;
      wr_addr_q  <= '0;
      cap_q      <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
      wr_ena_q   <= 1'b0;
      task_req_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      w_q        <= w_d;
      wr_addr_q  <= wr_addr_d;
      cap_q      <= cap_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      s_ready_q  <= s_ready_d;
      wr_ena_q   <= wr_ena_d;
      task_req_q <= task_req_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
    end
  end

  // Operand banks X/N/E; read address is the next wr_addr so RAM output matches wr_addr_q.
  for (genvar gi = 0; gi < 3; gi++) begin : g_op
    simple_ram #(.WIDTH(K), .WIDTHAD(AW+1), .DEEP(WORDS+1)) u_ram (
      .clk    (clk),
      .wren   (accept && (beat_q[BW-1:AW] == 2'(gi))),
      .wraddr ({1'b0, beat_q[AW-1:0]}),
      .data   (io.s_data),
      .rdaddr ({1'b0, wr_addr_d}),
      .q      (op_q[gi])
    );
  end

  // Result buffer read one word ahead via rd_d, so m_data holds while stalled.
  simple_ram #(.WIDTH(K), .WIDTHAD(AW+1), .DEEP(WORDS+1)) u_res_ram (
    .clk    (clk),
    .wren   (cap_ok),
    .wraddr (cap_q),
    .data   (io.task_res),
    .rdaddr (rd_d),
    .q      (res_q)
  );

  assign io.s_ready  = s_ready_q;
  assign io.wr_ena   = wr_ena_q;
  assign io.wr_addr  = wr_addr_q;
  assign io.wr_X     = wr_ena_q ? op_q[0] : '0;
  assign io.wr_N     = wr_ena_q ? op_q[1] : '0;
  assign io.wr_E     = wr_ena_q ? op_q[2] : '0;
  assign io.wr_W     = w_q;
  assign io.task_req = task_req_q;
  assign io.m_valid  = m_valid_q;
  assign io.m_data   = m_valid_q ? res_q : '0;
  assign io.m_last   = m_last_q;
  assign io.busy     = busy_q;
  assign io.err      = err_q;
endmodule
